// File: rtl/bcd_div_pkg.sv
// rtl/bcd_div_pkg.sv - shared constants for the digit-serial BCD divisibility checker
package bcd_div_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DIV_3  = 3;
  localparam int DIV_11 = 11;
endpackage

// File: rtl/bcd_mod_step.sv
// rtl/bcd_mod_step.sv - one Horner step: (10*r + digit) mod D by restoring shift-subtract
module bcd_mod_step #(
  parameter int DIV_W = 4
) (
  input  logic [DIV_W-1:0] i_r,
  input  logic [3:0]       i_digit,
  input  logic [DIV_W-1:0] i_div,
  output logic [DIV_W-1:0] o_rem
);
  localparam int VW = DIV_W + 4;

  logic [VW-1:0] w_r_ext;
  logic [VW-1:0] w_d_ext;
  logic [VW-1:0] w_acc;

  assign w_r_ext = VW'(i_r);
  assign w_d_ext = VW'(i_div);

  // With r < D the step input stays below 16*D, so four trial subtractions suffice.
  always_comb begin
    w_acc = (w_r_ext << 3) + (w_r_ext << 1) + VW'(i_digit);
    for (int k = 3; k >= 0; k--) begin
      if (w_acc >= (w_d_ext << k)) begin
        w_acc = w_acc - (w_d_ext << k);
      end
    end
    o_rem = (i_div == '0) ? '0 : DIV_W'(w_acc);
  end
endmodule

// File: rtl/bcd_div_checker_seq.sv
// rtl/bcd_div_checker_seq.sv - digit-serial BCD divisibility checker; BCD_DIV_LEGACY_EN selects fixed 3/11 divisor
module bcd_div_checker_seq
  import bcd_div_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int DIV_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BCD_DIV_LEGACY_EN
  input  logic             div_11_n3,
`else
  input  logic [DIV_W-1:0] divisor,
`endif
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DIV_W-1:0] res_remainder,
  output logic             res_divisible,
  output logic             res_err,
  output logic             res_trunc,
  output logic             busy
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_trunc;

  logic [DIV_W-1:0] w_start_div;
  logic [DIV_W-1:0] w_next_rem;
  logic             w_accept;
  logic             w_done;
  logic             w_final;

`ifdef BCD_DIV_LEGACY_EN
  if (DIV_W < 4) begin : g_div_w_check
    $error("bcd_div_checker_seq: legacy mode needs DIV_W >= 4 to hold divisor 11");
  end
  assign w_start_div = div_11_n3 ? DIV_W'(DIV_11) : DIV_W'(DIV_3);
`else
  assign w_start_div = divisor;
`endif

  bcd_mod_step #(.DIV_W(DIV_W)) u_step (
    .i_r     (r_rem),
    .i_digit (digit),
    .i_div   (r_div),
    .o_rem   (w_next_rem)
  );

  assign w_done   = (r_state == ST_DONE);
  assign w_accept = (r_state == ST_RUN) && digit_valid;
  assign w_final  = digit_last || (r_cnt == CNT_W'(MAX_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_div   <= w_start_div;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_err   <= (w_start_div == '0);
            r_trunc <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_rem <= w_next_rem;
            r_cnt <= r_cnt + 1'b1;
            if (digit > BCD_MAX) begin
              r_err <= 1'b1;
            end
            if (w_final) begin
              r_state <= ST_DONE;
              r_trunc <= ~digit_last;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result fields only show outside DONE as zero, so reset and idle look identical.
  assign digit_ready   = (r_state == ST_RUN);
  assign busy          = (r_state != ST_IDLE);
  assign res_valid     = w_done;
  assign res_remainder = w_done ? r_rem : '0;
  assign res_divisible = w_done && (r_rem == '0) && !r_err;
  assign res_err       = w_done && r_err;
  assign res_trunc     = w_done && r_trunc;
endmodule

// File: tb/tb_bcd_div_checker_seq.sv
// tb/tb_bcd_div_checker_seq.sv - directed-vector bench for bcd_div_checker_seq
module tb_bcd_div_checker_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
`ifdef BCD_DIV_LEGACY_EN
  logic       div_11_n3 = 1'b0;
`else
  logic [3:0] divisor = 4'd0;
`endif
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_last = 1'b0;
  logic       digit_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_remainder;
  logic       res_divisible;
  logic       res_err;
  logic       res_trunc;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_div_checker_seq #(.MAX_DIGITS(8), .DIV_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
`ifdef BCD_DIV_LEGACY_EN
    .div_11_n3     (div_11_n3),
`else
    .divisor       (divisor),
`endif
    .digit_valid   (digit_valid),
    .digit         (digit),
    .digit_last    (digit_last),
    .digit_ready   (digit_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_remainder (res_remainder),
    .res_divisible (res_divisible),
    .res_err       (res_err),
    .res_trunc     (res_trunc),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_num(input logic [3:0] d);
    @(negedge clk);
`ifdef BCD_DIV_LEGACY_EN
    div_11_n3 = (d == 4'd11);
`else
    divisor = d;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] dg, input logic last);
    int n;
    n = 0;
    digit_valid = 1'b1;
    digit = dg;
    digit_last = last;
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!digit_ready) chk("digit_ready_timeout", 0, 1);
    @(negedge clk);
    digit_valid = 1'b0;
    digit_last = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [3:0] rem, input logic dv,
                               input logic er, input logic tr);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_rem"}, res_remainder, rem);
    chk({tag, "_div"}, res_divisible, dv);
    chk({tag, "_err"}, res_err, er);
    chk({tag, "_trunc"}, res_trunc, tr);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic run4(input string tag, input logic [3:0] d, input logic [15:0] digs,
                      input logic [3:0] rem, input logic dv);
    start_num(d);
    for (int i = 3; i >= 0; i--) send_digit(digs[i*4 +: 4], i == 0);
    expect_result(tag, rem, dv, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", digit_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_div", res_divisible, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", digit_ready, 0);

    run4("d3_3235", 4'd3, 16'h3235, 4'd1, 1'b0);
    run4("d11_3235", 4'd11, 16'h3235, 4'd1, 1'b0);
    run4("d11_3234", 4'd11, 16'h3234, 4'd0, 1'b1);
    run4("d3_9899", 4'd3, 16'h9899, 4'd2, 1'b0);
    run4("d11_9899", 4'd11, 16'h9899, 4'd10, 1'b0);

`ifndef BCD_DIV_LEGACY_EN
    run4("d7_1001", 4'd7, 16'h1001, 4'd0, 1'b1);

    // Truncation: eight digits accepted, the ninth must be held off.
    start_num(4'd9);
    for (int i = 0; i < 8; i++) send_digit(4'd1, 1'b0);
    digit_valid = 1'b1;
    digit = 4'd1;
    chk("trunc_ready_low", digit_ready, 0);
    chk("trunc_valid", res_valid, 1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_rem", res_remainder, 8);
      chk("hold_trunc", res_trunc, 1);
      chk("hold_ready_low", digit_ready, 0);
    end
    start = 1'b0;
    digit_valid = 1'b0;
    expect_result("d9_trunc", 4'd8, 1'b0, 1'b0, 1'b1);

    start_num(4'd0);
    send_digit(4'd4, 1'b0);
    send_digit(4'd2, 1'b1);
    expect_result("d0_42", 4'd0, 1'b0, 1'b1, 1'b0);

    start_num(4'd5);
    send_digit(4'd1, 1'b0);
    send_digit(4'd12, 1'b0);
    send_digit(4'd5, 1'b1);
    expect_result("d5_bad", 4'd0, 1'b0, 1'b1, 1'b0);

    start_num(4'd13);
    send_digit(4'd0, 1'b1);
    expect_result("d13_0", 4'd0, 1'b1, 1'b0, 1'b0);

    start_num(4'd1);
    send_digit(4'd7, 1'b0);
    send_digit(4'd3, 1'b1);
    expect_result("d1_73", 4'd0, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a number.
    start_num(4'd3);
    send_digit(4'd2, 1'b0);
    send_digit(4'd2, 1'b0);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", digit_ready, 0);
    chk("async_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_num(4'd11);
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd1, 1'b1);
    expect_result("post_rst_121", 4'd0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1);
  end
endmodule
